// File: rtl/uart_rx_pkg.sv
// Shared UART receiver definitions: default line settings, frame width and FSM encoding.
// Compile with UART_RX_PARITY_EN defined for 8E1 frames; the default build is 8N1.
package uart_rx_pkg;

  localparam int DEFAULT_CLK_FREQ = 100_000_000;
  localparam int DEFAULT_BAUD     = 9600;
  localparam int DATA_BITS        = 8;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    PARITY    = 3'd3,
    STOP      = 3'd4,
    WAIT_HIGH = 3'd5
  } rx_state_t;

  // Integer division; the result must be at least 4 for mid-bit sampling to work.
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Multi-flop synchroniser for an asynchronous level input; flops reset to 1 (idle line).
module uart_rx_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '1;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], d};
    end
  end

  assign q = sync_reg[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// UART receiver, 8N1 LSB first with mid-bit sampling; 8E1 when UART_RX_PARITY_EN is defined.
// A stop bit sampled low raises frame_err and waits for the line to return high.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLK_FREQ     = DEFAULT_CLK_FREQ,
  parameter int BAUD         = DEFAULT_BAUD,
  parameter int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD)
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_busy,
  output logic       frame_err,
  output logic       parity_err
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);

  logic rx_s;

  rx_state_t            state_reg, state_next;
  logic [CNT_W-1:0]     clk_cnt_reg, clk_cnt_next;
  logic [2:0]           bit_idx_reg, bit_idx_next;
  logic [DATA_BITS-1:0] shift_reg, shift_next;
  logic [DATA_BITS-1:0] data_reg, data_next;
  logic                 valid_reg, valid_next;
  logic                 ferr_reg, ferr_next;
  logic                 perr_reg, perr_next;
  logic                 parity_fail;

  uart_rx_sync #(.STAGES(2)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx),
    .q   (rx_s)
  );

`ifdef UART_RX_PARITY_EN
  logic parity_bad_reg, parity_bad_next;

  always_ff @(posedge clk) begin
    if (rst) begin
      parity_bad_reg <= 1'b0;
    end else begin
      parity_bad_reg <= parity_bad_next;
    end
  end

  assign parity_fail = parity_bad_reg;
`else
  assign parity_fail = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      clk_cnt_reg <= '0;
      bit_idx_reg <= '0;
      shift_reg   <= '0;
      data_reg    <= '0;
      valid_reg   <= 1'b0;
      ferr_reg    <= 1'b0;
      perr_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      clk_cnt_reg <= clk_cnt_next;
      bit_idx_reg <= bit_idx_next;
      shift_reg   <= shift_next;
      data_reg    <= data_next;
      valid_reg   <= valid_next;
      ferr_reg    <= ferr_next;
      perr_reg    <= perr_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    clk_cnt_next = clk_cnt_reg;
    bit_idx_next = bit_idx_reg;
    shift_next   = shift_reg;
    data_next    = data_reg;
    valid_next   = 1'b0;
    ferr_next    = 1'b0;
    perr_next    = 1'b0;
`ifdef UART_RX_PARITY_EN
    parity_bad_next = parity_bad_reg;
`endif

    case (state_reg)
      IDLE: begin
        clk_cnt_next = '0;
        if (!rx_s) begin
          state_next = START;
        end
      end

      // Re-check the start bit at its centre so short glitches are rejected.
      START: begin
        if (clk_cnt_reg == CNT_HALF) begin
          clk_cnt_next = '0;
          bit_idx_next = '0;
          state_next   = rx_s ? IDLE : DATA;
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_ONE;
        end
      end

      DATA: begin
        if (clk_cnt_reg == CNT_LAST) begin
          clk_cnt_next            = '0;
          shift_next[bit_idx_reg] = rx_s;
          if (bit_idx_reg == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_ONE;
        end
      end

`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt_reg == CNT_LAST) begin
          clk_cnt_next    = '0;
          parity_bad_next = (rx_s != (^shift_reg));
          state_next      = STOP;
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_ONE;
        end
      end
`endif

      // Leaving at mid stop bit gives half a bit of slack for the next start edge.
      STOP: begin
        if (clk_cnt_reg == CNT_LAST) begin
          clk_cnt_next = '0;
          if (rx_s) begin
            if (parity_fail) begin
              perr_next = 1'b1;
            end else begin
              data_next  = shift_reg;
              valid_next = 1'b1;
            end
            state_next = IDLE;
          end else begin
            ferr_next  = 1'b1;
            state_next = WAIT_HIGH;
          end
        end else begin
          clk_cnt_next = clk_cnt_reg + CNT_ONE;
        end
      end

      WAIT_HIGH: begin
        clk_cnt_next = '0;
        if (rx_s) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next   = IDLE;
        clk_cnt_next = '0;
      end
    endcase
  end

  assign rx_data    = data_reg;
  assign rx_valid   = valid_reg;
  assign rx_busy    = (state_reg != IDLE);
  assign frame_err  = ferr_reg;
  assign parity_err = perr_reg;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: directed bit-banged frames push expected pulses, a monitor pops them.
// Build with UART_RX_PARITY_EN defined to also exercise the even-parity frames.
module tb_uart_rx;

  localparam int CPB = 16;
  localparam logic [1:0] K_VALID = 2'd0;
  localparam logic [1:0] K_FERR  = 2'd1;
  localparam logic [1:0] K_PERR  = 2'd2;

  typedef struct packed {
    logic [1:0] kind;
    logic [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_busy;
  logic       frame_err;
  logic       parity_err;

  ev_t exp_q[$];
  int  total  = 0;
  int  passed = 0;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ     (100_000_000),
    .BAUD         (9600),
    .CLKS_PER_BIT (CPB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx         (rx),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_busy    (rx_busy),
    .frame_err  (frame_err),
    .parity_err (parity_err)
  );

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act === exp) begin
      passed++;
      $display("ok   %s: got %02h", name, act);
    end else begin
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic pop_event(input logic [1:0] kind);
    ev_t ev;
    if (exp_q.size() == 0) begin
      total++;
      $display("FAIL unexpected_pulse: kind %0d with rx_data %02h, expected no pulse", kind, rx_data);
    end else begin
      ev = exp_q.pop_front();
      check("pulse_kind", 8'(kind), 8'(ev.kind));
      check("pulse_data", rx_data, ev.data);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid)   pop_event(K_VALID);
    if (frame_err)  pop_event(K_FERR);
    if (parity_err) pop_event(K_PERR);
  end

  task automatic hold_bit(input logic b);
    rx = b;
    repeat (CPB) @(negedge clk);
  endtask

  // Start, 8 data bits LSB first, optional parity bit, stop bit.
  task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
    hold_bit(1'b0);
    for (int i = 0; i < 8; i++) hold_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    hold_bit(par);
`else
    if (par) begin end
`endif
    hold_bit(stop);
  endtask

  task automatic idle_bits(input int n);
    rx = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  task automatic push(input logic [1:0] kind, input logic [7:0] d);
    ev_t ev;
    ev.kind = kind;
    ev.data = d;
    exp_q.push_back(ev);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("reset_rx_data", rx_data, 8'h00);
    check("reset_rx_valid", 8'(rx_valid), 8'h00);
    check("reset_rx_busy", 8'(rx_busy), 8'h00);
    check("reset_frame_err", 8'(frame_err), 8'h00);
    check("reset_parity_err", 8'(parity_err), 8'h00);
    rst = 1'b0;
    idle_bits(1);

    // Single frame 0x55 (parity bit for 0x55 is 0).
    push(K_VALID, 8'h55);
    send_frame(8'h55, 1'b0, 1'b1);
    idle_bits(2);
    check("t1_busy_after", 8'(rx_busy), 8'h00);
    check("t1_queue_drained", 8'(exp_q.size()), 8'h00);

    // Back-to-back frames, no idle between stop and next start.
    push(K_VALID, 8'hA5);
    push(K_VALID, 8'h3C);
    send_frame(8'hA5, 1'b0, 1'b1);
    send_frame(8'h3C, 1'b0, 1'b1);
    idle_bits(2);
    check("t2_queue_drained", 8'(exp_q.size()), 8'h00);

    // Three-cycle glitch: START entered, rejected before mid-bit.
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    check("t3_busy_on_glitch", 8'(rx_busy), 8'h01);
    repeat (CPB / 2 + 4) @(negedge clk);
    check("t3_busy_cleared", 8'(rx_busy), 8'h00);
    idle_bits(1);

    // Stop bit low then break for three bit periods: one frame_err, data held at 0x3C.
    push(K_FERR, 8'h3C);
    send_frame(8'h81, 1'b0, 1'b0);
    rx = 1'b0;
    repeat (3 * CPB) @(negedge clk);
    check("t4_busy_in_break", 8'(rx_busy), 8'h01);
    idle_bits(2);
    check("t4_busy_after", 8'(rx_busy), 8'h00);
    check("t4_queue_drained", 8'(exp_q.size()), 8'h00);

    // Reset during data bit 4 of 0xF0.
    hold_bit(1'b0);
    for (int i = 0; i < 4; i++) hold_bit(1'b0);
    rx = 1'b1;
    repeat (CPB / 2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("t5_rst_rx_data", rx_data, 8'h00);
    check("t5_rst_busy", 8'(rx_busy), 8'h00);
    check("t5_rst_valid", 8'(rx_valid), 8'h00);
    check("t5_rst_frame_err", 8'(frame_err), 8'h00);
    rst = 1'b0;
    idle_bits(2);
    push(K_VALID, 8'h12);
    send_frame(8'h12, 1'b0, 1'b1);
    idle_bits(2);
    check("t5_queue_drained", 8'(exp_q.size()), 8'h00);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1.
    push(K_PERR, 8'h12);
    send_frame(8'h07, 1'b0, 1'b1);
    idle_bits(2);
    push(K_VALID, 8'h07);
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(2);
    check("t6_queue_drained", 8'(exp_q.size()), 8'h00);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
